// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: sequential PC fetch with one outstanding read,
// a small PC/instruction FIFO toward decode, and redirect flush handling.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP      = 32'h1300_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_busy,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t        fifo_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_q, pc_d, opc_q, opc_d;
  logic          pending_q, pending_d, drop_q, drop_d;
  logic          has_space, accept, rsp, push, pop;
  logic          unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  // Outstanding read is counted against FIFO space; pops this cycle are not credited.
  assign has_space = ({1'b0, count_q} + {{CW{1'b0}}, pending_q}) < (CW+1)'(DEPTH);
  assign mem_req   = !reset && !redirect_valid && !drop_q && has_space &&
                     (!pending_q || mem_rvalid);
  assign mem_addr  = {pc_q[31:2], 2'b00};
  assign accept    = mem_req && !mem_busy;
  assign rsp       = pending_q && mem_rvalid;
  assign push      = rsp && !drop_q && !redirect_valid;
  assign inst_valid = (count_q != '0);
  assign pop       = inst_valid && inst_ready && !redirect_valid;
  assign inst_data = inst_valid ? fifo_q[rd_ptr_q].data : NOP;
  assign inst_pc   = inst_valid ? fifo_q[rd_ptr_q].pc   : 32'h0;

  always_comb begin
    pc_d      = pc_q;
    opc_d     = opc_q;
    pending_d = pending_q;
    drop_d    = drop_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    if (redirect_valid) begin
      pc_d      = {redirect_pc[31:2], 2'b00};
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      // A read still in flight now belongs to the old path; mark it for discard.
      pending_d = pending_q && !mem_rvalid;
      drop_d    = pending_q && !mem_rvalid;
    end else begin
      if (accept) begin
        pc_d  = pc_q + 32'd4;
        opc_d = mem_addr;
      end
      pending_d = accept || (pending_q && !mem_rvalid);
      if (rsp) drop_d = 1'b0;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      opc_q     <= '0;
      pending_q <= 1'b0;
      drop_q    <= 1'b0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      opc_q     <= opc_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) fifo_q[wr_ptr_q] <= '{pc: opc_q, data: mem_rdata};
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus a randomized run against a
// queue-based model of the fetch stream.
module tb_inst_fetch_unit;
  localparam logic [31:0] K        = 32'hA5A5_0000;
  localparam logic [31:0] NOP_V    = 32'h1300_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        reset, mem_req, mem_busy, mem_rvalid, redirect_valid;
  logic        inst_valid, inst_ready;
  logic [31:0] mem_addr, mem_rdata, redirect_pc, inst_data, inst_pc;

  int   errors = 0;
  int   checks = 0;
  bit   ideal  = 1'b0;
  logic        acc_s;
  logic [31:0] addr_s;

  inst_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP(NOP_V)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_busy(mem_busy), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  // Advance one clock; in ideal mode memory answers this cycle's accept next cycle.
  task automatic step();
    acc_s  = mem_req & !mem_busy;
    addr_s = mem_addr;
    @(posedge clk); #1;
    if (ideal) begin
      mem_rvalid = acc_s;
      mem_rdata  = addr_s ^ K;
    end
  endtask

  task automatic do_reset();
    ideal = 1'b0;
    reset = 1'b1; mem_busy = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    step();
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", mem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", inst_valid); end
    checks++; if (inst_data !== NOP_V) begin errors++; $display("FAIL rst_data got=%h exp=%h", inst_data, NOP_V); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=0", inst_pc); end
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_first_req got=%b exp=1", mem_req); end
    checks++; if (mem_addr !== RESET_PC) begin errors++; $display("FAIL rst_first_addr got=%h exp=%h", mem_addr, RESET_PC); end
    step();
  endtask

  task automatic test_streaming();
    do_reset();
    ideal = 1'b1; inst_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'(4*k)) begin errors++; $display("FAIL stream_req k=%0d got=%b/%h exp=1/%h", k, mem_req, mem_addr, 32'(4*k)); end
      if (k >= 2) begin
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4*(k-2)) || inst_data !== (32'(4*(k-2)) ^ K))
          begin errors++; $display("FAIL stream_inst k=%0d got=%b/%h/%h exp=1/%h/%h", k, inst_valid, inst_pc, inst_data, 32'(4*(k-2)), 32'(4*(k-2)) ^ K); end
      end else begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_early k=%0d got=%b exp=0", k, inst_valid); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int nacc = 0;
    int n = 0;
    do_reset();
    ideal = 1'b1; inst_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_req && !mem_busy) nacc++;
      step();
    end
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_full got=%b exp=0", mem_req); end
    checks++; if (nacc != DEPTH) begin errors++; $display("FAIL bp_fetches got=%0d exp=%0d", nacc, DEPTH); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL bp_head got=%b/%h exp=1/0", inst_valid, inst_pc); end
    step();
    inst_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (inst_valid) begin
        checks++; if (inst_pc !== 32'(4*n) || inst_data !== (32'(4*n) ^ K))
          begin errors++; $display("FAIL bp_drain n=%0d got=%h/%h exp=%h/%h", n, inst_pc, inst_data, 32'(4*n), 32'(4*n) ^ K); end
        n++;
      end
      step();
    end
    checks++; if (n != 10) begin errors++; $display("FAIL bp_pops got=%0d exp=10", n); end
  endtask

  task automatic test_busy();
    int n8 = 0;
    int npop = 0;
    do_reset();
    ideal = 1'b1; inst_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      mem_busy = (k >= 2 && k <= 4);
      @(negedge clk);
      if (mem_busy) begin
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin errors++; $display("FAIL busy_hold k=%0d got=%b/%h exp=1/8", k, mem_req, mem_addr); end
      end
      if (k >= 4 && k <= 6) begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL busy_nopush k=%0d got=%b exp=0", k, inst_valid); end
      end
      if (mem_req && !mem_busy && mem_addr == 32'h8) n8++;
      if (inst_valid) begin
        checks++; if (inst_pc !== 32'(4*npop) || inst_data !== (32'(4*npop) ^ K))
          begin errors++; $display("FAIL busy_order n=%0d got=%h/%h exp=%h/%h", npop, inst_pc, inst_data, 32'(4*npop), 32'(4*npop) ^ K); end
        npop++;
      end
      step();
    end
    mem_busy = 1'b0;
    checks++; if (n8 != 1) begin errors++; $display("FAIL busy_once got=%0d exp=1", n8); end
    checks++; if (npop != 7) begin errors++; $display("FAIL busy_pops got=%0d exp=7", npop); end
  endtask

  task automatic test_redirect_pending();
    int n = 0;
    do_reset();
    ideal = 1'b1; inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 4) begin
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin errors++; $display("FAIL rdp_issue got=%b/%h exp=1/10", mem_req, mem_addr); end
      end
      step();
    end
    ideal = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rdp_wait got=%b exp=0", mem_req); end
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rdp_redir_req got=%b exp=0", mem_req); end
    step();
    redirect_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rdp_drop_req got=%b exp=0", mem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdp_flushed got=%b exp=0", inst_valid); end
    step();
    mem_rvalid = 1'b0; ideal = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL rdp_target got=%b/%h exp=1/40", mem_req, mem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdp_stale got=%b exp=0", inst_valid); end
    step();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (inst_valid) begin
        checks++; if (inst_pc !== 32'h40 + 32'(4*n) || inst_data !== ((32'h40 + 32'(4*n)) ^ K))
          begin errors++; $display("FAIL rdp_stream n=%0d got=%h/%h exp=%h", n, inst_pc, inst_data, 32'h40 + 32'(4*n)); end
        n++;
      end
      step();
    end
    checks++; if (n != 5) begin errors++; $display("FAIL rdp_pops got=%0d exp=5", n); end
  endtask

  task automatic test_redirect_rvalid_pop();
    do_reset();
    ideal = 1'b1; inst_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      step();
    end
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || mem_rvalid !== 1'b1) begin errors++; $display("FAIL rrp_setup got=%b/%h/%b exp=1/0/1", inst_valid, inst_pc, mem_rvalid); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rrp_req got=%b exp=0", mem_req); end
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("FAIL rrp_target got=%b/%h exp=1/200", mem_req, mem_addr); end
    checks++; if (inst_valid !== 1'b0 || inst_data !== NOP_V || inst_pc !== 32'h0) begin errors++; $display("FAIL rrp_empty got=%b/%h/%h exp=0/%h/0", inst_valid, inst_data, inst_pc, NOP_V); end
    step();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rrp_latency got=%b exp=0", inst_valid); end
    step();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst_data !== (32'h200 ^ K)) begin errors++; $display("FAIL rrp_first got=%b/%h/%h exp=1/200/%h", inst_valid, inst_pc, inst_data, 32'h200 ^ K); end
    step();
  endtask

  task automatic test_wrap_reset();
    do_reset();
    ideal = 1'b1; inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL wrap_redir_req got=%b exp=0", mem_req); end
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got=%b/%h exp=1/fffffffc", mem_req, mem_addr); end
    step();
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero got=%b/%h exp=1/0", mem_req, mem_addr); end
    step();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst_data !== (32'hFFFF_FFFC ^ K)) begin errors++; $display("FAIL wrap_inst got=%b/%h/%h exp=1/fffffffc", inst_valid, inst_pc, inst_data); end
    step();
    ideal = 1'b0; reset = 1'b1; mem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req got=%b exp=0", mem_req); end
    step();
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== RESET_PC) begin errors++; $display("FAIL mid_rst_state got=%b/%b/%h exp=0/1/%h", inst_valid, mem_req, mem_addr, RESET_PC); end
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0 || mem_req !== 1'b0 || mem_addr !== RESET_PC + 32'd4) begin errors++; $display("FAIL late_rsp got=%b/%b/%h exp=0/0/%h", inst_valid, mem_req, mem_addr, RESET_PC + 32'd4); end
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
    @(negedge clk);
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== RESET_PC || inst_data !== 32'h77) begin errors++; $display("FAIL post_rst_inst got=%b/%h/%h exp=1/%h/77", inst_valid, inst_pc, inst_data, RESET_PC); end
    step();
  endtask

  task automatic test_random();
    logic [63:0] mq[$];
    logic [31:0] m_pc, m_opc, exp_pc, exp_data;
    bit          m_pend, m_drop, exp_req, exp_valid, rsp;
    do_reset();
    m_pc = RESET_PC; m_opc = '0; m_pend = 1'b0; m_drop = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(0, 99) == 0);
      mem_busy       = ($urandom_range(0, 3) == 0);
      mem_rvalid     = m_pend ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      mem_rdata      = $urandom;
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom_range(0, 1) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
      inst_ready     = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_req   = !reset && !redirect_valid && !m_drop && (mq.size() + int'(m_pend) < DEPTH) && (!m_pend || mem_rvalid);
      exp_valid = (mq.size() != 0);
      exp_pc    = exp_valid ? mq[0][63:32] : 32'h0;
      exp_data  = exp_valid ? mq[0][31:0]  : NOP_V;
      checks++; if (mem_req !== exp_req) begin errors++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, mem_req, exp_req); end
      checks++; if (mem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, mem_addr, m_pc); end
      checks++; if (inst_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, inst_valid, exp_valid); end
      checks++; if (inst_pc !== exp_pc || inst_data !== exp_data) begin errors++; $display("FAIL rnd_head c=%0d got=%h/%h exp=%h/%h", c, inst_pc, inst_data, exp_pc, exp_data); end
      rsp = m_pend && mem_rvalid;
      if (reset) begin
        m_pc = RESET_PC; mq.delete(); m_pend = 1'b0; m_drop = 1'b0;
      end else if (redirect_valid) begin
        mq.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
        if (m_pend && !mem_rvalid) m_drop = 1'b1;
        else begin m_pend = 1'b0; m_drop = 1'b0; end
      end else begin
        if (mq.size() != 0 && inst_ready) void'(mq.pop_front());
        if (rsp) begin
          if (m_drop) m_drop = 1'b0;
          else mq.push_back({m_opc, mem_rdata});
        end
        if (exp_req && !mem_busy) begin
          m_opc = m_pc; m_pc = m_pc + 32'd4; m_pend = 1'b1;
        end else if (rsp) m_pend = 1'b0;
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_busy();
    test_redirect_pending();
    test_redirect_rvalid_pop();
    test_wrap_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
